// File: rtl/player_life_ctrl.sv
// Per-player life counter and die/respawn/blink sequencer, stepped in whole video frames.
// Drives the sprite renderer's visible input and the freeze / invulnerable / game-over flags.
module player_life_ctrl #(
  parameter int LIVES_INIT     = 3,
  parameter int RESPAWN_FRAMES = 60,
  parameter int BLINK_FRAMES   = 96,
  parameter int BLINK_PERIOD   = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       collision,
  input  logic       levelStart,
  input  logic       newGame,
  output logic       visible,
  output logic       invulnerable,
  output logic       freeze,
  output logic       gameOver,
  output logic [3:0] lives
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIVE,
    S_DYING,
    S_INVULN,
    S_GAME_OVER
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] lives_q, lives_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic [7:0] blink_cnt_q, blink_cnt_d;
  logic       phase_q, phase_d;
  logic       visible_q, visible_d;
  logic       invuln_q, invuln_d;
  logic       freeze_q, freeze_d;
  logic       game_over_q, game_over_d;
  logic       enter_state;

  always_comb begin
    state_d     = state_q;
    lives_d     = lives_q;
    frame_cnt_d = frame_cnt_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    enter_state = 1'b0;

    if (newGame) begin
      state_d     = S_IDLE;
      lives_d     = 4'(LIVES_INIT);
      enter_state = 1'b1;
    end else if (levelStart && state_q != S_GAME_OVER) begin
      state_d     = S_ALIVE;
      enter_state = 1'b1;
    end else if (collision && state_q == S_ALIVE) begin
      // The last life goes straight to game over instead of a respawn cycle.
      if (lives_q > 4'd1) begin
        lives_d = lives_q - 4'd1;
        state_d = S_DYING;
      end else begin
        lives_d = 4'd0;
        state_d = S_GAME_OVER;
      end
      enter_state = 1'b1;
    end else if (startOfFrame) begin
      case (state_q)
        S_DYING: begin
          if (frame_cnt_q == 8'(RESPAWN_FRAMES - 1)) begin
            state_d     = S_INVULN;
            enter_state = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        S_INVULN: begin
          // Leaving INVULN wins over a blink toggle on the same pulse.
          if (frame_cnt_q == 8'(BLINK_FRAMES - 1)) begin
            state_d     = S_ALIVE;
            enter_state = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
            if (blink_cnt_q == 8'(BLINK_PERIOD - 1)) begin
              blink_cnt_d = 8'd0;
              phase_d     = ~phase_q;
            end else begin
              blink_cnt_d = blink_cnt_q + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end

    if (enter_state) begin
      frame_cnt_d = 8'd0;
      blink_cnt_d = 8'd0;
      phase_d     = 1'b0;
    end
  end

  // Outputs are decoded from the next state so they register together with it.
  always_comb begin
    visible_d   = 1'b0;
    invuln_d    = 1'b0;
    freeze_d    = 1'b0;
    game_over_d = 1'b0;
    case (state_d)
      S_IDLE:      freeze_d = 1'b1;
      S_ALIVE:     visible_d = 1'b1;
      S_DYING: begin
        visible_d = 1'b1;
        freeze_d  = 1'b1;
        invuln_d  = 1'b1;
      end
      S_INVULN: begin
        visible_d = phase_d;
        invuln_d  = 1'b1;
      end
      S_GAME_OVER: begin
        freeze_d    = 1'b1;
        game_over_d = 1'b1;
      end
      default:     freeze_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= S_IDLE;
      lives_q     <= 4'(LIVES_INIT);
      frame_cnt_q <= 8'd0;
      blink_cnt_q <= 8'd0;
      phase_q     <= 1'b0;
      visible_q   <= 1'b0;
      invuln_q    <= 1'b0;
      freeze_q    <= 1'b1;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      frame_cnt_q <= frame_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      visible_q   <= visible_d;
      invuln_q    <= invuln_d;
      freeze_q    <= freeze_d;
      game_over_q <= game_over_d;
    end
  end

  assign visible      = visible_q;
  assign invulnerable = invuln_q;
  assign freeze       = freeze_q;
  assign gameOver     = game_over_q;
  assign lives        = lives_q;

endmodule

// File: tb/tb_player_life_ctrl.sv
// Self-checking bench for player_life_ctrl: directed scenarios plus random traffic
// compared against a frame-counting reference model.
module tb_player_life_ctrl;

  localparam int LI = 3;
  localparam int RF = 60;
  localparam int BF = 96;
  localparam int BP = 8;

  localparam int M_IDLE = 0;
  localparam int M_ALIVE = 1;
  localparam int M_DYING = 2;
  localparam int M_INVULN = 3;
  localparam int M_OVER = 4;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       collision = 1'b0;
  logic       levelStart = 1'b0;
  logic       newGame = 1'b0;
  logic       visible, invulnerable, freeze, gameOver;
  logic [3:0] lives;

  int checks = 0;
  int errors = 0;

  int m_mode = M_IDLE;
  int m_lives = LI;
  int m_pulses = 0;

  player_life_ctrl #(
    .LIVES_INIT(LI), .RESPAWN_FRAMES(RF), .BLINK_FRAMES(BF), .BLINK_PERIOD(BP)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .collision(collision),
    .levelStart(levelStart), .newGame(newGame), .visible(visible),
    .invulnerable(invulnerable), .freeze(freeze), .gameOver(gameOver), .lives(lives)
  );

  always #5 clk = ~clk;

  wire [7:0] act = {lives, visible, invulnerable, freeze, gameOver};

  // Expected {lives, visible, invulnerable, freeze, gameOver} from the model state.
  function automatic logic [7:0] exp_outs();
    logic v, inv, frz, go;
    v = 1'b0; inv = 1'b0; frz = 1'b0; go = 1'b0;
    case (m_mode)
      M_IDLE:   frz = 1'b1;
      M_ALIVE:  v = 1'b1;
      M_DYING:  begin v = 1'b1; inv = 1'b1; frz = 1'b1; end
      M_INVULN: begin v = ((m_pulses / BP) % 2) == 1; inv = 1'b1; end
      default:  begin frz = 1'b1; go = 1'b1; end
    endcase
    return {4'(m_lives), v, inv, frz, go};
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_lives = LI; m_pulses = 0;
  endtask

  task automatic model_update(input logic sof, input logic col, input logic ls, input logic ng);
    if (ng) begin
      m_mode = M_IDLE; m_lives = LI; m_pulses = 0;
    end else if (ls && m_mode != M_OVER) begin
      m_mode = M_ALIVE; m_pulses = 0;
    end else if (col && m_mode == M_ALIVE) begin
      m_pulses = 0;
      if (m_lives > 1) begin m_lives--; m_mode = M_DYING; end
      else begin m_lives = 0; m_mode = M_OVER; end
    end else if (sof && (m_mode == M_DYING || m_mode == M_INVULN)) begin
      m_pulses++;
      if (m_mode == M_DYING && m_pulses == RF) begin m_mode = M_INVULN; m_pulses = 0; end
      else if (m_mode == M_INVULN && m_pulses == BF) begin m_mode = M_ALIVE; m_pulses = 0; end
    end
  endtask

  // One clock with the given inputs; outputs are then stable for sampling.
  task automatic step(input logic sof, input logic col, input logic ls, input logic ng);
    startOfFrame = sof; collision = col; levelStart = ls; newGame = ng;
    @(posedge clk);
    model_update(sof, col, ls, ng);
    #1;
    startOfFrame = 1'b0; collision = 1'b0; levelStart = 1'b0; newGame = 1'b0;
  endtask

  task automatic run_frames(input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act !== {4'd3, 4'b0010}) begin
      errors++; $display("FAIL reset_values: got %b required %b", act, {4'd3, 4'b0010});
    end
    resetN = 1'b1;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (act !== exp_outs()) begin
      errors++; $display("FAIL idle_after_reset: got %b required %b", act, exp_outs());
    end
  endtask

  task automatic test_level_start();
    checks++;
    if (lives !== 4'd3 || visible !== 1'b0 || freeze !== 1'b1) begin
      errors++; $display("FAIL pre_level_start: got lives=%0d vis=%b frz=%b required 3 0 1", lives, visible, freeze);
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (act !== {4'd3, 4'b1000} || act !== exp_outs()) begin
      errors++; $display("FAIL level_start_alive: got %b required %b", act, {4'd3, 4'b1000});
    end
  endtask

  task automatic test_hit_sequence();
    for (int i = 0; i < 50; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (act !== exp_outs()) begin
        errors++; $display("FAIL hold_collision cyc %0d: got %b required %b", i, act, exp_outs());
      end
    end
    checks++;
    if (lives !== 4'd2) begin
      errors++; $display("FAIL single_decrement: got lives=%0d required 2", lives);
    end
    for (int p = 1; p <= RF + BF; p++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      checks++;
      if (act !== exp_outs()) begin
        errors++; $display("FAIL respawn pulse %0d: got %b required %b", p, act, exp_outs());
      end
      if (p == RF - 1) begin
        checks++;
        if (freeze !== 1'b1 || invulnerable !== 1'b1) begin
          errors++; $display("FAIL dying_len: pulse %0d got frz=%b inv=%b required 1 1", p, freeze, invulnerable);
        end
      end
      if (p == RF || p == RF + 7) begin
        checks++;
        if ({visible, invulnerable, freeze} !== 3'b010) begin
          errors++; $display("FAIL invuln_hidden: pulse %0d got %b required 010", p, {visible, invulnerable, freeze});
        end
      end
      if (p == RF + 8 || p == RF + 15) begin
        checks++;
        if (visible !== 1'b1) begin
          errors++; $display("FAIL invuln_shown: pulse %0d got vis=%b required 1", p, visible);
        end
      end
      if (p == RF + BF - 1) begin
        checks++;
        if (invulnerable !== 1'b1) begin
          errors++; $display("FAIL invuln_len: pulse %0d got inv=%b required 1", p, invulnerable);
        end
      end
      step(1'b0, 1'b0, 1'b0, 1'b0);
    end
    checks++;
    if (act !== {4'd2, 4'b1000}) begin
      errors++; $display("FAIL back_to_alive: got %b required %b", act, {4'd2, 4'b1000});
    end
  endtask

  task automatic test_collision_ignored();
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_frames(20);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (act !== {4'd1, 4'b1110} || act !== exp_outs()) begin
      errors++; $display("FAIL col_in_dying: got %b required %b", act, {4'd1, 4'b1110});
    end
    run_frames(RF - 20 + 3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (act !== {4'd1, 4'b0100} || act !== exp_outs()) begin
      errors++; $display("FAIL col_in_invuln: got %b required %b", act, {4'd1, 4'b0100});
    end
    run_frames(BF);
    checks++;
    if (act !== exp_outs()) begin
      errors++; $display("FAIL after_ignored: got %b required %b", act, exp_outs());
    end
  endtask

  task automatic test_game_over();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    for (int h = 1; h <= 3; h++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (lives !== 4'(3 - h)) begin
        errors++; $display("FAIL hit_%0d_lives: got %0d required %0d", h, lives, 3 - h);
      end
      if (h < 3) begin
        run_frames(RF + BF);
        checks++;
        if (act !== exp_outs() || {visible, invulnerable} !== 2'b10) begin
          errors++; $display("FAIL respawn_%0d: got %b required %b", h, act, exp_outs());
        end
      end
    end
    checks++;
    if (act !== {4'd0, 4'b0011}) begin
      errors++; $display("FAIL game_over: got %b required %b", act, {4'd0, 4'b0011});
    end
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (act !== {4'd0, 4'b0011}) begin
      errors++; $display("FAIL level_start_in_over: got %b required %b", act, {4'd0, 4'b0011});
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (act !== {4'd3, 4'b0010}) begin
      errors++; $display("FAIL new_game: got %b required %b", act, {4'd3, 4'b0010});
    end
  endtask

  task automatic test_simultaneous();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    checks++;
    if (act !== {4'd3, 4'b0010} || act !== exp_outs()) begin
      errors++; $display("FAIL simultaneous: got %b required %b", act, {4'd3, 4'b0010});
    end
  endtask

  task automatic test_reset_mid_dying();
    step(1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_frames(30);
    #2 resetN = 1'b0;
    #1;
    model_reset();
    checks++;
    if (act !== {4'd3, 4'b0010}) begin
      errors++; $display("FAIL async_reset: got %b required %b", act, {4'd3, 4'b0010});
    end
    @(posedge clk);
    #1 resetN = 1'b1;
    step(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (act !== {4'd3, 4'b1000}) begin
      errors++; $display("FAIL alive_after_reset: got %b required %b", act, {4'd3, 4'b1000});
    end
    // A fresh hit must run a full-length DYING with no leftover count.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_frames(RF - 1);
    checks++;
    if (act !== {4'd2, 4'b1110}) begin
      errors++; $display("FAIL no_partial_count: got %b required %b", act, {4'd2, 4'b1110});
    end
  endtask

  task automatic test_random();
    int col_hold = 0;
    logic sof, col, ls, ng;
    for (int i = 0; i < 6000; i++) begin
      sof = ($urandom_range(0, 2) == 0);
      if (col_hold > 0) col_hold--;
      else if ($urandom_range(0, 24) == 0) col_hold = $urandom_range(1, 30);
      col = (col_hold > 0);
      ls = ($urandom_range(0, 399) == 0);
      ng = ($urandom_range(0, 1499) == 0);
      step(sof, col, ls, ng);
      checks++;
      if (act !== exp_outs()) begin
        errors++; $display("FAIL random cyc %0d: got %b required %b", i, act, exp_outs());
      end
    end
  endtask

  initial begin
    test_reset();
    test_level_start();
    test_hit_sequence();
    test_collision_ignored();
    test_game_over();
    test_simultaneous();
    test_reset_mid_dying();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
